fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Write-side arbiter that shares the single write port of the FIFO top module between `NUM_REQ` independent producers in the write clock domain. Each cycle it selects at most one requesting producer by round-robin, forwards that producer's word to the FIFO write port, and returns a same-cycle acknowledge, never writing while the FIFO reports full. An optional burst mode holds ownership for up to `BURST_LEN` consecutive words so that one producer's packet lands contiguously in the FIFO.

## Interface
- `NUM_REQ`, 4: number of producers, range 2..8.
- `DATA_W`, 8: data width; matches FIFO `wr_data`.
- `BURST_LEN`, 4: maximum words per ownership in burst mode, range 2..16.
- `CNT_W`, 16: width of the transfer counter.

Ports:
- `clk`  in  1  write-domain clock; the same clock as the FIFO `wr_clk`.
- `rst_n`  in  1  synchronous, active-low reset.
- `req`  in  NUM_REQ  per-producer request; the producer holds it high while it has a word.
- `req_data`  in  NUM_REQ*DATA_W  producer words; slice i is bits [i*DATA_W +: DATA_W].
- `ack`  out  NUM_REQ  one-hot-or-zero, combinational; the word on slice i is consumed at this edge.
- `fifo_full`  in  1  FIFO `o_fifo_full`.
- `fifo_wr_en`  out  1  to FIFO `wr_en`.
- `fifo_wr_data`  out  DATA_W  to FIFO `wr_data`.
- `busy`  out  1  registered; high while the arbiter is in state OWN.
- `xfer_cnt`  out  CNT_W  registered count of accepted words; wraps modulo 2^CNT_W.

## Operation
- Registered state: `rr_ptr` (priority start index), `state` ∈ {IDLE, OWN}, `owner`, `beat_cnt`, `xfer_cnt`.
- Reset values: `rr_ptr`=0, `state`=IDLE, `owner`=0, `beat_cnt`=0, `busy`=0, `xfer_cnt`=0. While `rst_n`=0, `ack`, `fifo_wr_en` and `fifo_wr_data` are all 0, regardless of `req`.
- Arbitration in IDLE: the winner is the first index i with `req[i]`=1, scanning from `rr_ptr` upward and wrapping modulo `NUM_REQ`.
- Transfer occurs when a winner exists and `fifo_full`=0. On a transfer:
  - `ack[winner]`=1, `fifo_wr_en`=1, `fifo_wr_data`=`req_data` slice of the winner.
  - `xfer_cnt` increments at the clock edge.
- Otherwise `ack`=0, `fifo_wr_en`=0 and `fifo_wr_data`=0.
- Without burst mode, after each transfer `rr_ptr` ← winner+1, modulo `NUM_REQ`. `state` stays IDLE.
- `fifo_full`=1 blocks every transfer. `rr_ptr`, `state` and `beat_cnt` hold, so no requester loses its turn.
- Wrap-around: `rr_ptr` = `NUM_REQ`−1 followed by a grant to `NUM_REQ`−1 gives `rr_ptr`=0.

## Timing
- Zero-cycle grant: `ack` and `fifo_wr_*` are combinational from `req`, `fifo_full` and the registered state.
- The FIFO samples the word at the same `clk` edge.
- Throughput: one word per cycle while `fifo_full`=0.
- The producer must present its next word, or drop `req`, after the edge at which its `ack` was high.
- No combinational path from `ack` to `req` is allowed inside the arbiter.

## Configuration
- Macro `FIFO_WR_ARB_BURST_EN`.
- Defined: a transfer from IDLE moves to OWN with `owner`=winner and `beat_cnt`=1. In OWN:
  - Only `owner` is eligible. While `req[owner]`=1 and `fifo_full`=0, each cycle transfers and increments `beat_cnt`.
  - The transfer that makes `beat_cnt` equal `BURST_LEN` returns to IDLE with `rr_ptr` ← `owner`+1.
  - `fifo_full`=1: stall in OWN; the burst is not broken.
  - `req[owner]`=0: that same cycle, IDLE arbitration runs from `owner`+1, so there is no bubble. The state leaves OWN; it re-enters OWN only if the new winner transfers.
- Undefined: the OWN state, `owner` and `beat_cnt` are not built, and `busy` is tied to 0.

## Structure
- Shared package `fifo_wr_arb_pkg` holds:
  - the state enum {IDLE, OWN};
  - the function `rr_pick(req, ptr)`, which returns a valid flag and an index.
- One sub-module, `rr_priority_pick`: combinational rotate → priority-encode → un-rotate, parameterised by `NUM_REQ`.
- The top level holds the state registers, the data mux and the counters.

## Test plan
- Reset with `req`=4'b1111 held and `rst_n` low for 3 cycles → `ack`=0, `fifo_wr_en`=0, `xfer_cnt`=0. The first cycle after release grants index 0.
- `req`=4'b1111, `fifo_full`=0, no macro → `ack` sequence 0001, 0010, 0100, 1000, 0001. `xfer_cnt`=5 after 5 cycles. `fifo_wr_data` equals each winner's slice (0x34, 0xA8, 0x0F, 0xAB).
- `fifo_full` raised for 4 cycles mid-sequence after a grant to 1 → no `ack` and no `fifo_wr_en` during the stall. The next grant after `fifo_full` drops goes to 2.
- Burst mode, `req`=4'b0011, `BURST_LEN`=4 → `ack[0]` for 4 consecutive cycles with `busy`=1, then `ack[1]` for 4 cycles, then `ack[0]` again.
- Burst mode: `req[0]` drops after 2 beats while `req[2]`=1 → `ack[2]` the same cycle with no idle cycle, and `busy` stays 1 into the new burst.
- Set `xfer_cnt` to 0xFFFF (force, or run 65535 transfers), then perform one transfer → `xfer_cnt`=0x0000.

Source files
------------

// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Burst ownership is enabled by defining FIFO_WR_ARB_BURST_EN.
package fifo_wr_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  localparam int MAX_REQ = 8;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } pick_t;

  // Behavioural round-robin scan: first set bit at or after ptr, wrapping at n.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                    input logic [2:0]         ptr,
                                    input int                 n);
    pick_t p;
    int    j;
    p = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (k < n && !p.valid) begin
        j = (int'(ptr) + k) % n;
        if (req[j]) begin
          p.valid = 1'b1;
          p.idx   = 3'(j);
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_pick.sv
// Round-robin priority picker: rotate by ptr, take lowest set bit, rotate back.
module rr_priority_pick
  import fifo_wr_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  localparam logic [IDX_W:0] N_L = (IDX_W+1)'(NUM_REQ);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [IDX_W-1:0]     off;
  logic [IDX_W:0]       raw;
  logic [IDX_W:0]       sum;

  assign dbl = {req, req};
  assign rot = NUM_REQ'(dbl >> ptr);

  // Descending scan so the lowest rotated position wins.
  always_comb begin
    valid = 1'b0;
    off   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        valid = 1'b1;
        off   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    raw = {1'b0, ptr} + {1'b0, off};
    sum = (raw >= N_L) ? (raw - N_L) : raw;
  end

  assign idx = sum[IDX_W-1:0];

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Define FIFO_WR_ARB_BURST_EN to hold ownership for up to BURST_LEN words.
module fifo_wr_arbiter
  import fifo_wr_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  input  logic                      fifo_full,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_wr_data,
  output logic                      busy,
  output logic [CNT_W-1:0]          xfer_cnt
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_REQ - 1);

  function automatic logic [IDX_W-1:0] inc_idx(input logic [IDX_W-1:0] i);
    return (i == LAST) ? '0 : i + IDX_W'(1);
  endfunction

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] pick_ptr;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_vld;
  logic [IDX_W-1:0] win_idx;
  logic             win_vld;
  logic             xfer;

  rr_priority_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

`ifdef FIFO_WR_ARB_BURST_EN
  localparam int BW = $clog2(BURST_LEN + 1);

  arb_state_e       state, state_nxt;
  logic [IDX_W-1:0] owner, owner_nxt;
  logic [IDX_W-1:0] rr_ptr_nxt;
  logic [BW-1:0]    beat_cnt, beat_nxt;
  logic             hold;

  // A dropped owner request falls straight into arbitration from owner+1.
  assign hold     = (state == OWN) && req[owner];
  assign pick_ptr = (state == OWN) ? inc_idx(owner) : rr_ptr;
  assign win_vld  = hold | pick_vld;
  assign win_idx  = hold ? owner : pick_idx;
  assign busy     = (state == OWN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= '0;
      beat_cnt <= '0;
      rr_ptr   <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      beat_cnt <= beat_nxt;
      rr_ptr   <= rr_ptr_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    beat_nxt   = beat_cnt;
    rr_ptr_nxt = rr_ptr;
    if (!fifo_full) begin
      if (hold) begin
        if (beat_cnt == BW'(BURST_LEN - 1)) begin
          state_nxt  = IDLE;
          beat_nxt   = '0;
          rr_ptr_nxt = inc_idx(owner);
        end else begin
          beat_nxt = beat_cnt + BW'(1);
        end
      end else if (pick_vld) begin
        state_nxt = OWN;
        owner_nxt = pick_idx;
        beat_nxt  = BW'(1);
      end else if (state == OWN) begin
        state_nxt  = IDLE;
        beat_nxt   = '0;
        rr_ptr_nxt = inc_idx(owner);
      end
    end
  end
`else
  assign pick_ptr = rr_ptr;
  assign win_vld  = pick_vld;
  assign win_idx  = pick_idx;
  assign busy     = 1'b0;

  always_ff @(posedge clk) begin
    if (!rst_n)    rr_ptr <= '0;
    else if (xfer) rr_ptr <= inc_idx(win_idx);
  end
`endif

  // Gating with rst_n keeps the write port quiet while in reset.
  assign xfer       = rst_n & win_vld & ~fifo_full;
  assign fifo_wr_en = xfer;

  always_comb begin
    ack          = '0;
    fifo_wr_data = '0;
    if (xfer) begin
      ack[win_idx] = 1'b1;
      fifo_wr_data = req_data[int'(win_idx)*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)    xfer_cnt <= '0;
    else if (xfer) xfer_cnt <= xfer_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter; burst checks build when FIFO_WR_ARB_BURST_EN is defined.
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [7:0]  fifo_wr_data;
  logic        busy;
  logic [15:0] xfer_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_W(8), .BURST_LEN(4), .CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .req_data     (req_data),
    .ack          (ack),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .busy         (busy),
    .xfer_cnt     (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    req   = 4'b0000;
    fifo_full = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    req       = 4'b1111;
    req_data  = 32'hAB0FA834;
    fifo_full = 1'b0;
    rst_n     = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #3;
      n_checks++;
      if (ack !== 4'b0000) begin n_fail++; $display("FAIL reset_ack c%0d got %b want 0000", c, ack); end
      n_checks++;
      if (fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en c%0d got %b want 0", c, fifo_wr_en); end
      n_checks++;
      if (fifo_wr_data !== 8'h00) begin n_fail++; $display("FAIL reset_wr_data c%0d got %h want 00", c, fifo_wr_data); end
      tick();
      n_checks++;
      if (xfer_cnt !== 16'h0000) begin n_fail++; $display("FAIL reset_xfer_cnt c%0d got %h want 0000", c, xfer_cnt); end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy c%0d got %b want 0", c, busy); end
    end
    rst_n = 1'b1;
    #3;
    n_checks++;
    if (ack !== 4'b0001) begin n_fail++; $display("FAIL reset_first_grant got %b want 0001", ack); end
    tick();
    n_checks++;
    if (xfer_cnt !== 16'h0001) begin n_fail++; $display("FAIL reset_first_cnt got %h want 0001", xfer_cnt); end
  endtask

`ifndef FIFO_WR_ARB_BURST_EN
  task automatic test_round_robin;
    logic [3:0] ea [5];
    logic [7:0] ed [5];
    ea = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    ed = '{8'h34, 8'hA8, 8'h0F, 8'hAB, 8'h34};
    do_reset();
    req      = 4'b1111;
    req_data = 32'hAB0FA834;
    for (int c = 0; c < 5; c++) begin
      #3;
      n_checks++;
      if (ack !== ea[c]) begin n_fail++; $display("FAIL rr_ack c%0d got %b want %b", c, ack, ea[c]); end
      n_checks++;
      if (fifo_wr_en !== 1'b1) begin n_fail++; $display("FAIL rr_wr_en c%0d got %b want 1", c, fifo_wr_en); end
      n_checks++;
      if (fifo_wr_data !== ed[c]) begin n_fail++; $display("FAIL rr_data c%0d got %h want %h", c, fifo_wr_data, ed[c]); end
      tick();
    end
    n_checks++;
    if (xfer_cnt !== 16'd5) begin n_fail++; $display("FAIL rr_xfer_cnt got %0d want 5", xfer_cnt); end
  endtask

  task automatic test_full_stall;
    do_reset();
    req      = 4'b1111;
    req_data = 32'hAB0FA834;
    for (int c = 0; c < 2; c++) begin
      #3;
      n_checks++;
      if (ack !== (4'b0001 << c)) begin n_fail++; $display("FAIL stall_pre_ack c%0d got %b want %b", c, ack, 4'b0001 << c); end
      tick();
    end
    fifo_full = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #3;
      n_checks++;
      if (ack !== 4'b0000 || fifo_wr_en !== 1'b0) begin
        n_fail++; $display("FAIL stall_block c%0d got ack=%b wr_en=%b want 0000/0", c, ack, fifo_wr_en);
      end
      tick();
    end
    n_checks++;
    if (xfer_cnt !== 16'd2) begin n_fail++; $display("FAIL stall_cnt_hold got %0d want 2", xfer_cnt); end
    fifo_full = 1'b0;
    #3;
    n_checks++;
    if (ack !== 4'b0100) begin n_fail++; $display("FAIL stall_resume_ack got %b want 0100", ack); end
    n_checks++;
    if (fifo_wr_data !== 8'h0F) begin n_fail++; $display("FAIL stall_resume_data got %h want 0f", fifo_wr_data); end
    tick();
    n_checks++;
    if (xfer_cnt !== 16'd3) begin n_fail++; $display("FAIL stall_cnt_after got %0d want 3", xfer_cnt); end
  endtask

  task automatic test_wrap;
    do_reset();
    req_data = 32'h44332211;
    req = 4'b1000;
    #3;
    n_checks++;
    if (ack !== 4'b1000) begin n_fail++; $display("FAIL wrap_grant3 got %b want 1000", ack); end
    tick();
    req = 4'b1001;
    #3;
    n_checks++;
    if (ack !== 4'b0001) begin n_fail++; $display("FAIL wrap_to0 got %b want 0001", ack); end
    n_checks++;
    if (fifo_wr_data !== 8'h11) begin n_fail++; $display("FAIL wrap_data got %h want 11", fifo_wr_data); end
    tick();
    req = 4'b0000;
    #3;
    n_checks++;
    if (ack !== 4'b0000 || fifo_wr_en !== 1'b0 || fifo_wr_data !== 8'h00) begin
      n_fail++; $display("FAIL idle_noreq got ack=%b wr_en=%b data=%h want 0000/0/00", ack, fifo_wr_en, fifo_wr_data);
    end
    tick();
    req = 4'b0101;
    #3;
    n_checks++;
    if (ack !== 4'b0100) begin n_fail++; $display("FAIL sparse_first got %b want 0100", ack); end
    tick();
    #3;
    n_checks++;
    if (ack !== 4'b0001) begin n_fail++; $display("FAIL sparse_second got %b want 0001", ack); end
    tick();
  endtask
`else
  task automatic test_burst;
    logic [3:0] ea [9];
    logic       eb [9];
    ea = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
    eb = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    req      = 4'b0011;
    req_data = 32'hAB0FA834;
    for (int c = 0; c < 9; c++) begin
      #3;
      n_checks++;
      if (ack !== ea[c]) begin n_fail++; $display("FAIL burst_ack c%0d got %b want %b", c, ack, ea[c]); end
      n_checks++;
      if (busy !== eb[c]) begin n_fail++; $display("FAIL burst_busy c%0d got %b want %b", c, busy, eb[c]); end
      tick();
    end
  endtask

  task automatic test_burst_drop;
    do_reset();
    req      = 4'b0101;
    req_data = 32'hAB0FA834;
    for (int c = 0; c < 2; c++) begin
      #3;
      n_checks++;
      if (ack !== 4'b0001) begin n_fail++; $display("FAIL drop_pre c%0d got %b want 0001", c, ack); end
      tick();
    end
    req = 4'b0100;
    for (int c = 0; c < 2; c++) begin
      #3;
      n_checks++;
      if (ack !== 4'b0100) begin n_fail++; $display("FAIL drop_switch c%0d got %b want 0100", c, ack); end
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL drop_busy c%0d got %b want 1", c, busy); end
      tick();
    end
  endtask
`endif

  task automatic test_cnt_wrap;
    do_reset();
    req      = 4'b0001;
    req_data = 32'h000000C3;
    repeat (65535) tick();
    n_checks++;
    if (xfer_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL cnt_full got %h want ffff", xfer_cnt); end
    tick();
    n_checks++;
    if (xfer_cnt !== 16'h0000) begin n_fail++; $display("FAIL cnt_wrap got %h want 0000", xfer_cnt); end
    req = 4'b0000;
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = 4'b0000;
    req_data  = '0;
    fifo_full = 1'b0;
    test_reset();
`ifndef FIFO_WR_ARB_BURST_EN
    test_round_robin();
    test_full_stall();
    test_wrap();
`else
    test_burst();
    test_burst_drop();
`endif
    test_cnt_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
